// File: rtl/urv_cfg.sv
// urv_cfg: core-wide sizing constants shared by the memory-path blocks.
package urv_cfg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ARB_PORTS = 2;

endpackage

// File: rtl/urv_typedef.sv
// urv_typedef: memory channel payloads and arbiter state encoding.
package urv_typedef;

    import urv_cfg::*;

    typedef struct packed {
        logic [XLEN-1:0]   req_addr;
        logic [XLEN-1:0]   req_wdata;
        logic [XLEN/8-1:0] req_be;
        logic              req_we;
    } mem_req_t;

    typedef struct packed {
        logic [XLEN-1:0] resp_rdata;
        logic            resp_err;
    } mem_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arb_sel.sv
// mem_arb_sel: picks the winning requester index from the two valids.
// MEM_ARB_RR_EN: ties go to the requester that did not win last (round-robin);
// otherwise requester 0 always wins a tie.
module mem_arb_sel
    import urv_cfg::*;
(
    input  logic [ARB_PORTS-1:0] valid,
    input  logic                 last_owner,
    output logic                 grant
);

`ifdef MEM_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    // Lone requester always wins; a tie follows the configured policy
    always_comb begin
        grant = 1'b0;
        if (valid == 2'b10) begin
            grant = 1'b1;
        end else if (valid == 2'b11) begin
            grant = RR_EN ? ~last_owner : 1'b0;
        end
    end

endmodule

// File: rtl/mem_arb2.sv
// mem_arb2: two-requester arbiter in front of mem2ahb, one transaction in flight.
// Build option MEM_ARB_RR_EN selects round-robin tie-break (default: s0 priority).
module mem_arb2
    import urv_cfg::*;
    import urv_typedef::*;
(
    input  logic      clk,
    input  logic      rst,

    input  logic      s0_req_valid,
    output logic      s0_req_ready,
    input  mem_req_t  s0_req,
    output logic      s0_resp_valid,
    input  logic      s0_resp_ready,
    output mem_resp_t s0_resp,

    input  logic      s1_req_valid,
    output logic      s1_req_ready,
    input  mem_req_t  s1_req,
    output logic      s1_resp_valid,
    input  logic      s1_resp_ready,
    output mem_resp_t s1_resp,

    output logic      m_req_valid,
    input  logic      m_req_ready,
    output mem_req_t  m_req,
    input  logic      m_resp_valid,
    output logic      m_resp_ready,
    input  mem_resp_t m_resp,

    output logic      busy,
    output logic      owner
);

    arb_state_e           state;
    arb_state_e           state_nxt;
    logic [ARB_PORTS-1:0] valid_c;
    logic                 grant_c;
    logic                 accept_c;
    logic                 resp_ready_c;

    assign valid_c  = {s1_req_valid, s0_req_valid};
    assign accept_c = (state == IDLE) && !rst && (|valid_c);
    assign busy     = (state != IDLE);
    assign s0_resp  = m_resp;
    assign s1_resp  = m_resp;

    mem_arb_sel u_sel (
        .valid      (valid_c),
        .last_owner (owner),
        .grant      (grant_c)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus handshake decode for both sides
    always_comb begin
        state_nxt     = state;
        s0_req_ready  = 1'b0;
        s1_req_ready  = 1'b0;
        m_req_valid   = 1'b0;
        resp_ready_c  = 1'b0;
        s0_resp_valid = 1'b0;
        s1_resp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    s0_req_ready = ~grant_c;
                    s1_req_ready = grant_c;
                    state_nxt    = REQ;
                end
            end
            REQ: begin
                m_req_valid = 1'b1;
                if (m_req_ready) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_ready_c  = owner ? s1_resp_ready : s0_resp_ready;
                s0_resp_valid = ~owner & m_resp_valid;
                s1_resp_valid = owner & m_resp_valid;
                if (m_resp_valid && resp_ready_c) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign m_resp_ready = resp_ready_c;

    // Capture winner index and its payload on grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner <= 1'b0;
            m_req <= '0;
        end else if (accept_c) begin
            owner <= grant_c;
            m_req <= grant_c ? s1_req : s0_req;
        end
    end

endmodule

// File: tb/tb_mem_arb2.sv
// tb_mem_arb2: directed scoreboard bench for mem_arb2 with a small mem2ahb model.
module tb_mem_arb2;

    import urv_typedef::*;

    logic      clk;
    logic      rst;
    logic      s0_req_valid, s0_req_ready, s0_resp_valid, s0_resp_ready;
    logic      s1_req_valid, s1_req_ready, s1_resp_valid, s1_resp_ready;
    mem_req_t  s0_req, s1_req, m_req;
    mem_resp_t s0_resp, s1_resp, m_resp;
    logic      m_req_valid, m_req_ready, m_resp_valid, m_resp_ready;
    logic      busy, owner;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] exp_mreq [$];
    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];
    logic [31:0] mem [logic [31:0]];
    logic        slave_stall = 1'b0;
    logic        stray_resp  = 1'b0;

    mem_arb2 dut (
        .clk           (clk),
        .rst           (rst),
        .s0_req_valid  (s0_req_valid),
        .s0_req_ready  (s0_req_ready),
        .s0_req        (s0_req),
        .s0_resp_valid (s0_resp_valid),
        .s0_resp_ready (s0_resp_ready),
        .s0_resp       (s0_resp),
        .s1_req_valid  (s1_req_valid),
        .s1_req_ready  (s1_req_ready),
        .s1_req        (s1_req),
        .s1_resp_valid (s1_resp_valid),
        .s1_resp_ready (s1_resp_ready),
        .s1_resp       (s1_resp),
        .m_req_valid   (m_req_valid),
        .m_req_ready   (m_req_ready),
        .m_req         (m_req),
        .m_resp_valid  (m_resp_valid),
        .m_resp_ready  (m_resp_ready),
        .m_resp        (m_resp),
        .busy          (busy),
        .owner         (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic mem_req_t rd(input logic [31:0] a);
        mem_req_t r;
        r = '0;
        r.req_addr = a;
        r.req_be   = 4'hF;
        return r;
    endfunction

    function automatic mem_req_t wr(input logic [31:0] a, input logic [31:0] d);
        mem_req_t r;
        r = rd(a);
        r.req_wdata = d;
        r.req_we    = 1'b1;
        return r;
    endfunction

    // Raise a request on port n and hold it until granted (bounded)
    task automatic issue(input int n, input mem_req_t r);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        if (n == 0) begin s0_req_valid = 1'b1; s0_req = r; end
        else        begin s1_req_valid = 1'b1; s1_req = r; end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((n == 0) ? s0_req_ready : s1_req_ready) begin got = 1'b1; break; end
        end
        @(posedge clk); #1;
        if (n == 0) s0_req_valid = 1'b0;
        else        s1_req_valid = 1'b0;
        n_total++;
        if (got) n_pass++;
        else $display("FAIL grant_timeout_s%0d: got no ready, want ready within 40 cycles", n);
    endtask

    // Wait until every expected transfer has been seen and the arbiter is idle
    task automatic wait_drain(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!busy && exp0.size() == 0 && exp1.size() == 0 && exp_mreq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL drain_%s: got busy=%0b pending=%0d/%0d/%0d, want all done", tag, busy,
                      exp_mreq.size(), exp0.size(), exp1.size());
    endtask

    // mem2ahb model: checks grant order, answers one cycle after accept
    initial begin
        mem_resp_t rsp;
        mem_req_t  areq;
        logic      pend, acc, done;
        pend = 1'b0; rsp = '0;
        m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp = '0;
        forever begin
            @(negedge clk);
            acc  = m_req_valid && m_req_ready;
            done = m_resp_valid && m_resp_ready;
            areq = m_req;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (done) pend = 1'b0;
                if (acc) begin
                    if (exp_mreq.size() == 0) begin
                        n_total++;
                        $display("FAIL m_req_unexpected: got addr 0x%0h, want no request", areq.req_addr);
                    end else begin
                        chk("m_req_addr", areq.req_addr, exp_mreq.pop_front());
                    end
                    rsp = '0;
                    if (areq.req_we) mem[areq.req_addr] = areq.req_wdata;
                    else rsp.resp_rdata = mem.exists(areq.req_addr) ? mem[areq.req_addr] : areq.req_addr;
                    pend = 1'b1;
                end
            end
            @(posedge clk); #1;
            m_req_ready  = !slave_stall;
            m_resp_valid = pend || stray_resp;
            if (pend) m_resp = rsp;
            else      m_resp = '{resp_rdata: 32'h0000_0BAD, resp_err: 1'b0};
        end
    end

    // Response monitor and per-cycle protocol invariants
    always @(negedge clk) begin
        if (s0_resp_valid && s0_resp_ready) begin
            if (exp0.size() == 0) begin
                n_total++;
                $display("FAIL s0_resp_unexpected: got rdata 0x%0h, want none", s0_resp.resp_rdata);
            end else chk("s0_rdata", s0_resp.resp_rdata, exp0.pop_front());
        end
        if (s1_resp_valid && s1_resp_ready) begin
            if (exp1.size() == 0) begin
                n_total++;
                $display("FAIL s1_resp_unexpected: got rdata 0x%0h, want none", s1_resp.resp_rdata);
            end else chk("s1_rdata", s1_resp.resp_rdata, exp1.pop_front());
        end
        chk("invariant", 32'((busy && (s0_req_ready || s1_req_ready)) ||
                              (s0_resp_valid && s1_resp_valid) ||
                              (s0_req_ready && s1_req_ready) ||
                              (m_req_valid && !busy)), 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200us");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        s0_req_valid = 1'b1; s0_req = wr(32'h4, 32'h4); s0_resp_ready = 1'b1;
        s1_req_valid = 1'b0; s1_req = '0;                s1_resp_ready = 1'b1;

        // Reset values, with a request already pending
        repeat (2) @(negedge clk);
        chk("rst_s0_req_ready", 32'(s0_req_ready), 32'd0);
        chk("rst_m_req_valid",  32'(m_req_valid),  32'd0);
        chk("rst_busy",         32'(busy),         32'd0);
        chk("rst_owner",        32'(owner),        32'd0);
        chk("rst_m_resp_ready", 32'(m_resp_ready), 32'd0);
        chk("rst_m_req_addr",   m_req.req_addr,    32'd0);
        @(posedge clk); #1;
        s0_req_valid = 1'b0;
        rst = 1'b0;

        // s0 alone writes 0x4: ready now, m_req_valid next cycle
        @(posedge clk); #1;
        exp_mreq.push_back(32'h4); exp0.push_back(32'h0);
        s0_req_valid = 1'b1; s0_req = wr(32'h4, 32'h4);
        @(negedge clk);
        chk("t1_s0_req_ready", 32'(s0_req_ready), 32'd1);
        chk("t1_s1_req_ready", 32'(s1_req_ready), 32'd0);
        chk("t1_m_req_valid0", 32'(m_req_valid),  32'd0);
        @(posedge clk); #1;
        s0_req_valid = 1'b0;
        @(negedge clk);
        chk("t1_m_req_valid1", 32'(m_req_valid),  32'd1);
        chk("t1_m_req_addr",   m_req.req_addr,    32'h4);
        chk("t1_owner",        32'(owner),        32'd0);
        chk("t1_busy",         32'(busy),         32'd1);
        wait_drain("t1");

        // Stray response in IDLE is neither routed nor accepted
        stray_resp = 1'b1;
        @(negedge clk);
        chk("stray_m_resp_ready", 32'(m_resp_ready), 32'd0);
        chk("stray_resp_valid",   32'({s1_resp_valid, s0_resp_valid}), 32'd0);
        stray_resp = 1'b0;
        @(negedge clk);

        // Tie in IDLE with owner=0
`ifdef MEM_ARB_RR_EN
        exp_mreq.push_back(32'hC); exp_mreq.push_back(32'h8);
`else
        exp_mreq.push_back(32'h8); exp_mreq.push_back(32'hC);
`endif
        exp0.push_back(32'h8); exp1.push_back(32'hC);
        fork
            issue(0, rd(32'h8));
            issue(1, rd(32'hC));
        join
        wait_drain("tie");

        // s1 holds off its response for 5 cycles while s0 waits
        s1_resp_ready = 1'b0;
        exp_mreq.push_back(32'h14); exp1.push_back(32'h14);
        issue(1, rd(32'h14));
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (s1_resp_valid) begin seen = 1'b1; break; end
            end
            chk("hold_resp_seen", 32'(seen), 32'd1);
        end
        exp_mreq.push_back(32'h20); exp0.push_back(32'h20);
        fork
            issue(0, rd(32'h20));
        join_none
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_m_resp_ready", 32'(m_resp_ready),  32'd0);
            chk("hold_busy",         32'(busy),          32'd1);
            chk("hold_s0_req_ready", 32'(s0_req_ready),  32'd0);
            chk("hold_owner",        32'(owner),         32'd1);
        end
        @(posedge clk); #1;
        s1_resp_ready = 1'b1;
        wait_drain("hold");
        wait fork;

        // Reset while a request from s1 sits in REQ
        slave_stall = 1'b1;
        issue(1, rd(32'h18));
        @(negedge clk);
        chk("mid_m_req_valid", 32'(m_req_valid), 32'd1);
        chk("mid_owner",       32'(owner),       32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_m_req_valid", 32'(m_req_valid), 32'd0);
        chk("mid_rst_busy",        32'(busy),        32'd0);
        chk("mid_rst_owner",       32'(owner),       32'd0);
        chk("mid_rst_m_req_addr",  m_req.req_addr,   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        slave_stall = 1'b0;

        // Fresh s0 write to 0x10, then s1 reads it back
        exp_mreq.push_back(32'h10); exp0.push_back(32'h0);
        issue(0, wr(32'h10, 32'hDEAD_BEEF));
        wait_drain("post_rst_wr");
        exp_mreq.push_back(32'h10); exp1.push_back(32'hDEAD_BEEF);
        issue(1, rd(32'h10));
        wait_drain("post_rst_rd");
        chk("final_owner", 32'(owner), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arb2.md
MEM_ARB2 -- requirements
Module: mem_arb2

Interface
REQ-001 The block SHALL have no parameters; channel types SHALL be mem_req_t and mem_resp_t from urv_typedef.
REQ-002 The port list SHALL be, one per line, name  direction  width  meaning, with clock and reset first:
  clk  in  1  single clock, rising edge.
  rst  in  1  asynchronous, active-high reset.
  s0_req_valid  in  1  requester 0 (fetch) request valid.
  s0_req_ready  out  1  requester 0 request accepted.
  s0_req  in  mem_req_t  requester 0 payload.
  s0_resp_valid  out  1  response valid to requester 0.
  s0_resp_ready  in  1  requester 0 can take response.
  s0_resp  out  mem_resp_t  response payload to requester 0.
  s1_*  same as s0_*  requester 1 (load/store).
  m_req_valid  out  1  request valid to mem2ahb.
  m_req_ready  in  1  mem2ahb request ready.
  m_req  out  mem_req_t  registered winning payload.
  m_resp_valid  in  1  mem2ahb response valid.
  m_resp_ready  out  1  response ready to mem2ahb.
  m_resp  in  mem_resp_t  mem2ahb response.
  busy  out  1  transaction in flight (state != IDLE).
  owner  out  1  current/last granted requester index.

Function
REQ-003 FSM states SHALL be IDLE, REQ, RESP; at most one transaction SHALL be outstanding.
REQ-004 In IDLE, if any sN_req_valid is high, the winner SHALL get sN_req_ready=1 in that cycle, its payload SHALL be captured into m_req, owner SHALL update, and state SHALL go to REQ; the loser's ready SHALL stay 0.
REQ-005 sN_req_ready SHALL be 0 in every state other than IDLE.
REQ-006 In REQ, m_req_valid SHALL be 1 and m_req SHALL hold stable; on m_req_valid&&m_req_ready the state SHALL go to RESP.
REQ-007 In RESP, s[owner]_resp_valid SHALL equal m_resp_valid, s[owner]_resp SHALL equal m_resp, and m_resp_ready SHALL equal s[owner]_resp_ready; the non-owner's resp_valid SHALL be 0.
REQ-008 On m_resp_valid&&m_resp_ready in RESP the state SHALL return to IDLE; a new grant SHALL be possible in the next cycle (minimum 3 cycles per transaction, accept to next accept).
REQ-009 Both requesters valid in IDLE SHALL resolve per REQ-013; a single valid requester SHALL always win.
REQ-010 m_resp_valid outside RESP SHALL be ignored (no routing, m_resp_ready=0).
REQ-011 m_req_valid SHALL be 0 in IDLE and RESP.

Reset
REQ-012 While rst=1, at any point including mid-transaction: state=IDLE, m_req_valid=0, m_req=0, m_resp_ready=0, sN_req_ready=0, sN_resp_valid=0, busy=0, owner=0; the in-flight transaction SHALL be dropped.

Configuration
REQ-013 With MEM_ARB_RR_EN defined, ties SHALL go to the requester that is not owner (round-robin); without it, ties SHALL go to requester 0 (fixed priority).

Structure
REQ-014 The FSM state enum (arb_state_e) SHALL live in urv_typedef; the port count constant SHALL live in urv_cfg.
REQ-015 Tie-break logic SHALL be a sub-module, mem_arb_sel (inputs valid[1:0], last owner; output grant index).

Verification
REQ-016 Requester 0 only writes 0x0000_0004 to 0x4 -> s0_req_ready high 1 cycle, m_req_valid the next cycle with req_addr=0x4; s0_resp_valid on completion; owner=0.
REQ-017 Both valid in IDLE (s0 read 0x8, s1 read 0xC), MEM_ARB_RR_EN defined, owner=0 -> s1 granted first, then s0; read data 0xC then 0x8.
REQ-018 Same stimulus without MEM_ARB_RR_EN -> s0 granted first, s1 second.
REQ-019 In RESP, s1_resp_ready held 0 for 5 cycles -> m_resp_ready=0 for those cycles, busy=1, no new grant; completes when released.
REQ-020 rst asserted while in REQ -> next edge shows m_req_valid=0, busy=0, owner=0; a fresh s0 write to 0x10 then completes normally.
